awe_weight_distributor_mc: RTL and testbench
============================================

# awe_weight_distributor_mc

Multi-lane weight distributor for the AWE convolution datapath. It accepts a configuration packet, loads one weight bank per output lane from a single write stream, then replays each bank to its lane on demand, in kernel-major or map-major order selected at run time. It generalises the two-port (upper/lower) distributor to C_LANES independent lanes on one clock, with fixed read latency, per-lane last flags and configuration bounds checking.

## Interface
- C_LANES, 4, number of output lanes and weight banks (1..16)
- C_WORD_WIDTH, 32, width of one table word (two packed weights)
- C_BANK_DEPTH, 256, words per bank; power of two
- C_ADDR_WIDTH, 8, log2(C_BANK_DEPTH)
- C_PACKET_WIDTH, 32, config packet width (>= 25)

- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- config_valid  in  1  config packet strobe
- config_packet  in  C_PACKET_WIDTH  [5:0] kernels_m1, [13:6] kwords_m1, [23:14] maps_m1, [24] mode; upper bits ignored
- config_error  out  1  one-cycle pulse: config rejected
- write_weights_valid  in  1  weight word offered
- write_weights_ready  out  1  word accepted when valid&&ready
- weight_input  in  C_WORD_WIDTH  weight word
- weight_request  in  C_LANES  per-lane read request
- weight_output  out  C_LANES*C_WORD_WIDTH  lane i at [i*C_WORD_WIDTH +: C_WORD_WIDTH]
- weight_valid  out  C_LANES  per-lane data valid
- weight_last  out  C_LANES  qualifies final word of lane sequence
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, all lanes finished

## Operation
- K = kernels_m1+1, W = kwords_m1+1, M = maps_m1+1; values stored minus-one, so zero means one.
- States: IDLE, FILL, READ, DONE.
- IDLE: config_valid latches the fields. If K*W > C_BANK_DEPTH, pulse config_error and stay in IDLE. Otherwise clear the fill counters and go to FILL. config_valid outside IDLE is ignored.
- FILL: write_weights_ready=1. Each accepted word goes to bank b, address a. Order is bank 0 addresses 0..K*W-1, then bank 1, and so on. After the L*K*W-th accepted word: ready drops the next cycle, per-lane counters clear, go to READ. write_weights_valid in any other state is ignored, with ready=0.
- READ: each lane advances independently. Word index w steps fastest.
  - mode 0 (all inputs first): loops k, then m, then w; address = k*W + w.
  - mode 1 (all kernels first): loops m, then k, then w; address = k*W + w.
  - A lane's sequence is K*M*W words.
  - A request on lane i is accepted when the lane is not finished. Acceptance issues the current address and advances the counters.
  - The lane is finished after its last word is issued. Further requests on a finished lane are ignored and produce no valid.
  - Address arithmetic: k*W computed at C_ADDR_WIDTH bits, never exceeds C_BANK_DEPTH-1 given the config check.
- When all lanes are finished and the last valid has been driven, go to DONE, pulse done, then return to IDLE.
- Table contents persist across jobs and are not cleared by rst.

## Timing
- Reset values: config_error=0, write_weights_ready=0, weight_valid=0, weight_last=0, busy=0, done=0, weight_output=0; state=IDLE.
- rst mid-fill or mid-read aborts the job. Outputs take reset values the next cycle. Partial bank contents are undefined.
- Config acceptance to write_weights_ready=1: 1 cycle.
- Read latency: a request accepted in cycle t gives weight_valid[i]=1 with data in cycle t+1. weight_last[i] is high in the same cycle as the final word. There is no startup bubble.
- A lane requesting every cycle gets one word per cycle. Lanes never stall each other; all lanes may read in the same cycle.
- weight_valid and weight_last are low in every cycle without an accepted request in the previous cycle.
- weight_output holds its last value when valid is low.
- DONE lasts exactly 1 cycle. busy falls the cycle after done. A new config is accepted the cycle busy=0.

## Test plan
- Reset then idle: all outputs 0, write_weights_ready=0, busy=0; config with kernels_m1=15, kwords_m1=31 (K*W=512 > 256) -> config_error pulses once, busy stays 0.
- C_LANES=4, K=2, W=3, M=2, mode 0, fill words 0..23: lane 0 continuous requests return 0,1,2,0,1,2,3,4,5,3,4,5; weight_last with the 12th word; lane 3 returns 18..23 in the same pattern.
- Same fill, mode 1: lane 1 returns 6,7,8,9,10,11,6,7,8,9,10,11; each valid exactly 1 cycle after its request.
- Lanes interleaved, lane 2 requesting every third cycle while the others stream: per-lane sequences are unchanged. done pulses 1 cycle after the final valid across all lanes. Extra requests after a lane's last word give no valid.
- write_weights_valid toggling randomly during fill: exactly L*K*W words stored, ready deasserts after the last word, and readback matches.
- rst asserted mid-READ: next cycle all outputs 0, busy=0; a new config is accepted immediately after.

Source files
------------

// File: rtl/awe_weight_distributor_mc.sv
// -----------------------------------------------------------------------------
// awe_weight_distributor_mc
//
// Multi-lane weight distributor for the AWE convolution datapath. A config
// packet sizes the job, one write stream fills a weight bank per lane, and
// each lane then replays its bank on request in kernel-major (mode 0) or
// map-major (mode 1) order with one cycle of read latency.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   config_valid/packet   job configuration: [5:0] kernels_m1,
//                         [13:6] kwords_m1, [23:14] maps_m1, [24] mode
//   config_error          one-cycle pulse when a packet is rejected
//   write_weights_*       valid/ready weight fill stream
//   weight_input          weight word being filled
//   weight_request        per-lane read request
//   weight_output         lane i at [i*C_WORD_WIDTH +: C_WORD_WIDTH]
//   weight_valid/last     per-lane data valid and final-word flag
//   busy                  job in progress (state != IDLE)
//   done                  one-cycle pulse when all lanes have finished
// -----------------------------------------------------------------------------
module awe_weight_distributor_mc #(
  parameter int unsigned C_LANES        = 4,
  parameter int unsigned C_WORD_WIDTH   = 32,
  parameter int unsigned C_BANK_DEPTH   = 256,
  parameter int unsigned C_ADDR_WIDTH   = 8,
  parameter int unsigned C_PACKET_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              config_valid,
  input  logic [C_PACKET_WIDTH-1:0]         config_packet,
  output logic                              config_error,
  input  logic                              write_weights_valid,
  output logic                              write_weights_ready,
  input  logic [C_WORD_WIDTH-1:0]           weight_input,
  input  logic [C_LANES-1:0]                weight_request,
  output logic [C_LANES*C_WORD_WIDTH-1:0]   weight_output,
  output logic [C_LANES-1:0]                weight_valid,
  output logic [C_LANES-1:0]                weight_last,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned BANK_W = (C_LANES > 1) ? $clog2(C_LANES) : 1;
  // wide enough for 64*256 and for C_BANK_DEPTH itself
  localparam int unsigned PROD_W = (C_ADDR_WIDTH + 1 > 15) ? C_ADDR_WIDTH + 1 : 15;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              state;
  logic [1:0]              next_state;

  logic [5:0]              kernels_m1;
  logic [7:0]              kwords_m1;
  logic [9:0]              maps_m1;
  logic                    mode;
  logic [C_ADDR_WIDTH-1:0] kw_last;
  logic [C_ADDR_WIDTH-1:0] w_step;

  logic [C_ADDR_WIDTH-1:0] fill_addr;
  logic [BANK_W-1:0]       fill_bank;

  logic [PROD_W-1:0]       pkt_k;
  logic [PROD_W-1:0]       pkt_w;
  logic [PROD_W-1:0]       pkt_kw;
  logic                    pkt_too_big;
  logic                    cfg_seen;
  logic                    cfg_accept;
  logic                    fill_accept;
  logic                    fill_bank_end;
  logic                    fill_final;
  logic [C_LANES-1:0]      lane_fin;
  logic                    all_fin;

  // Upper packet bits carry nothing for this block.
  if (C_PACKET_WIDTH > 25) begin : g_pkt_spare
    logic unused_pkt_bits;
    assign unused_pkt_bits = ^config_packet[C_PACKET_WIDTH-1:25];
  end

  // Bounds check on the incoming packet: K*W must fit in one bank.
  assign pkt_k       = PROD_W'(config_packet[5:0]) + PROD_W'(1);
  assign pkt_w       = PROD_W'(config_packet[13:6]) + PROD_W'(1);
  assign pkt_kw      = pkt_k * pkt_w;
  assign pkt_too_big = pkt_kw > PROD_W'(C_BANK_DEPTH);

  assign cfg_seen      = (state == S_IDLE) && config_valid;
  assign cfg_accept    = cfg_seen && !pkt_too_big;
  assign fill_accept   = (state == S_FILL) && write_weights_valid;
  assign fill_bank_end = (fill_addr == kw_last);
  assign fill_final    = fill_accept && fill_bank_end &&
                         (fill_bank == BANK_W'(C_LANES - 1));
  assign all_fin       = &lane_fin;

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (cfg_accept) next_state = S_FILL;
      S_FILL: if (fill_final) next_state = S_READ;
      S_READ: if (all_fin)    next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register, job configuration, fill counters and control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      kernels_m1          <= '0;
      kwords_m1           <= '0;
      maps_m1             <= '0;
      mode                <= 1'b0;
      kw_last             <= '0;
      w_step              <= '0;
      fill_addr           <= '0;
      fill_bank           <= '0;
      config_error        <= 1'b0;
      write_weights_ready <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      state               <= next_state;
      config_error        <= cfg_seen && pkt_too_big;
      write_weights_ready <= (next_state == S_FILL);
      busy                <= (next_state != S_IDLE);
      done                <= (next_state == S_DONE);

      if (cfg_seen) begin
        kernels_m1 <= config_packet[5:0];
        kwords_m1  <= config_packet[13:6];
        maps_m1    <= config_packet[23:14];
        mode       <= config_packet[24];
        kw_last    <= C_ADDR_WIDTH'(pkt_kw - PROD_W'(1));
        w_step     <= C_ADDR_WIDTH'(pkt_w);
      end

      if (cfg_accept) begin
        fill_addr <= '0;
        fill_bank <= '0;
      end else if (fill_accept) begin
        if (fill_bank_end) begin
          fill_addr <= '0;
          fill_bank <= fill_bank + BANK_W'(1);
        end else begin
          fill_addr <= fill_addr + C_ADDR_WIDTH'(1);
        end
      end
    end
  end

  // One bank, sequencer and output register per lane.
  for (genvar gi = 0; gi < C_LANES; gi++) begin : g_lane
    logic [C_WORD_WIDTH-1:0] bank [C_BANK_DEPTH];
    logic [C_WORD_WIDTH-1:0] data;
    logic [C_ADDR_WIDTH-1:0] kbase;
    logic [C_ADDR_WIDTH-1:0] addr;
    logic [7:0]              w_cnt;
    logic [5:0]              k_cnt;
    logic [9:0]              m_cnt;
    logic                    fin;
    logic                    valid;
    logic                    last;
    logic                    acc;
    logic                    w_wrap;
    logic                    k_wrap;
    logic                    m_wrap;
    logic                    at_end;

    // Bank contents survive reset; only the fill stream writes them.
    always_ff @(posedge clk) begin
      if (fill_accept && (fill_bank == BANK_W'(gi))) begin
        bank[fill_addr] <= weight_input;
      end
    end

    assign acc    = (state == S_READ) && weight_request[gi] && !fin;
    assign w_wrap = (w_cnt == kwords_m1);
    assign k_wrap = (k_cnt == kernels_m1);
    assign m_wrap = (m_cnt == maps_m1);
    assign at_end = w_wrap && k_wrap && m_wrap;
    // kbase tracks k*W incrementally so no per-lane multiplier is needed
    assign addr   = kbase + C_ADDR_WIDTH'(w_cnt);

    always_ff @(posedge clk) begin
      if (rst) begin
        kbase <= '0;
        w_cnt <= '0;
        k_cnt <= '0;
        m_cnt <= '0;
        fin   <= 1'b0;
        valid <= 1'b0;
        last  <= 1'b0;
        data  <= '0;
      end else begin
        valid <= acc;
        last  <= acc && at_end;
        if (acc) begin
          data <= bank[addr];
        end

        if (fill_final) begin
          kbase <= '0;
          w_cnt <= '0;
          k_cnt <= '0;
          m_cnt <= '0;
          fin   <= 1'b0;
        end else if (acc) begin
          if (at_end) begin
            fin <= 1'b1;
          end
          if (!w_wrap) begin
            w_cnt <= w_cnt + 8'd1;
          end else begin
            w_cnt <= '0;
            if (!mode) begin
              // kernel-major: maps step before kernels
              if (!m_wrap) begin
                m_cnt <= m_cnt + 10'd1;
              end else begin
                m_cnt <= '0;
                k_cnt <= k_cnt + 6'd1;
                kbase <= kbase + w_step;
              end
            end else begin
              // map-major: kernels step before maps
              if (!k_wrap) begin
                k_cnt <= k_cnt + 6'd1;
                kbase <= kbase + w_step;
              end else begin
                k_cnt <= '0;
                kbase <= '0;
                m_cnt <= m_cnt + 10'd1;
              end
            end
          end
        end
      end
    end

    assign lane_fin[gi]                                    = fin;
    assign weight_valid[gi]                                = valid;
    assign weight_last[gi]                                 = last;
    assign weight_output[gi*C_WORD_WIDTH +: C_WORD_WIDTH]  = data;
  end

endmodule

// File: tb/tb_awe_weight_distributor_mc.sv
// -----------------------------------------------------------------------------
// tb_awe_weight_distributor_mc
//
// Directed bench for awe_weight_distributor_mc with four lanes. Jobs use
// K=2, W=3, M=2 and fill words 0..23, so bank b holds b*6+0 .. b*6+5.
// Expected lane sequences are hand-written offset tables added to b*6.
// -----------------------------------------------------------------------------
module tb_awe_weight_distributor_mc;

  localparam int unsigned LANES = 4;
  localparam int unsigned WW    = 32;
  localparam int unsigned SEQ   = 12;

  logic                 clk;
  logic                 rst;
  logic                 config_valid;
  logic [31:0]          config_packet;
  logic                 config_error;
  logic                 write_weights_valid;
  logic                 write_weights_ready;
  logic [WW-1:0]        weight_input;
  logic [LANES-1:0]     weight_request;
  logic [LANES*WW-1:0]  weight_output;
  logic [LANES-1:0]     weight_valid;
  logic [LANES-1:0]     weight_last;
  logic                 busy;
  logic                 done;

  int checks;
  int errors;

  // hand-computed offsets within a bank for K=2, W=3, M=2
  int pat_mode0 [SEQ] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
  int pat_mode1 [SEQ] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};

  awe_weight_distributor_mc #(
    .C_LANES        (LANES),
    .C_WORD_WIDTH   (WW),
    .C_BANK_DEPTH   (256),
    .C_ADDR_WIDTH   (8),
    .C_PACKET_WIDTH (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .config_valid        (config_valid),
    .config_packet       (config_packet),
    .config_error        (config_error),
    .write_weights_valid (write_weights_valid),
    .write_weights_ready (write_weights_ready),
    .weight_input        (weight_input),
    .weight_request      (weight_request),
    .weight_output       (weight_output),
    .weight_valid        (weight_valid),
    .weight_last         (weight_last),
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pkt(input int km1, input int wm1, input int mm1, input int md);
    return {7'd0, 1'(md), 10'(mm1), 8'(wm1), 6'(km1)};
  endfunction

  // Fill 24 words 0..23, optionally with a random gap pattern on valid.
  task automatic fill(input bit toggle);
    int n;
    int guard;
    bit v;
    n = 0;
    guard = 0;
    while (n < 24 && guard < 200) begin
      if (write_weights_ready !== 1'b1) check("fill_ready", write_weights_ready, 1);
      v = toggle ? 1'($urandom % 2) : 1'b1;
      write_weights_valid = v;
      weight_input = 32'(n);
      tick();
      if (v) n++;
      guard++;
    end
    write_weights_valid = 1'b0;
    if (n != 24) check("fill_timeout", 0, 1);
    check("ready_drop", write_weights_ready, 0);
    check("busy_read", busy, 1);
    // an offer outside FILL must be ignored
    write_weights_valid = 1'b1;
    weight_input = 32'hDEAD_BEEF;
    tick();
    write_weights_valid = 1'b0;
    check("ready_read", write_weights_ready, 0);
  endtask

  task automatic start_job(input int md, input bit toggle);
    config_valid = 1'b1;
    config_packet = pkt(1, 2, 1, md);
    tick();
    config_valid = 1'b0;
    check("cfg_ready", write_weights_ready, 1);
    check("cfg_busy", busy, 1);
    check("cfg_noerr", config_error, 0);
    fill(toggle);
  endtask

  // Stream all lanes; with interleave, lane 2 requests every third cycle.
  // Finished lanes keep requesting to show extra requests are ignored.
  task automatic run_read(input bit md, input bit interleave);
    int cnt [LANES];
    bit acc [LANES];
    logic [LANES-1:0] req;
    int cyc;
    bit all_done;
    int exp_data;
    for (int i = 0; i < int'(LANES); i++) cnt[i] = 0;
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 60) begin
      for (int i = 0; i < int'(LANES); i++) begin
        req[i] = (interleave && i == 2) ? (cyc % 3 == 0) : 1'b1;
        acc[i] = req[i] && (cnt[i] < int'(SEQ));
      end
      weight_request = req;
      tick();
      cyc++;
      for (int i = 0; i < int'(LANES); i++) begin
        check($sformatf("valid_l%0d_c%0d", i, cyc), weight_valid[i], acc[i]);
        if (acc[i]) begin
          exp_data = i * 6 + (md ? pat_mode1[cnt[i]] : pat_mode0[cnt[i]]);
          check($sformatf("data_l%0d_w%0d", i, cnt[i]), weight_output[i*WW +: WW], 64'(exp_data));
          check($sformatf("last_l%0d_w%0d", i, cnt[i]), weight_last[i], cnt[i] == int'(SEQ) - 1);
          cnt[i]++;
        end else begin
          check($sformatf("last_idle_l%0d_c%0d", i, cyc), weight_last[i], 0);
        end
      end
      all_done = 1'b1;
      for (int i = 0; i < int'(LANES); i++) if (cnt[i] < int'(SEQ)) all_done = 1'b0;
    end
    if (!all_done) check("read_timeout", 0, 1);
    check("done_early", done, 0);
    weight_request = '1;
    tick();
    check("valid_after_end", weight_valid, 0);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    weight_request = '0;
    tick();
    check("done_clear", done, 0);
    check("busy_clear", busy, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    config_valid = 1'b0;
    config_packet = '0;
    write_weights_valid = 1'b0;
    weight_input = '0;
    weight_request = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_ready", write_weights_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cerr", config_error, 0);
    check("rst_valid", weight_valid, 0);
    check("rst_last", weight_last, 0);
    check("rst_out", weight_output, 0);

    // K*W = 16*32 = 512 rejected
    config_valid = 1'b1;
    config_packet = pkt(15, 31, 0, 0);
    tick();
    config_valid = 1'b0;
    check("cerr_pulse", config_error, 1);
    check("cerr_busy", busy, 0);
    check("cerr_ready", write_weights_ready, 0);
    tick();
    check("cerr_clear", config_error, 0);
    check("cerr_idle", busy, 0);

    // K*W = 4*64 = 256 exactly fits, then abort with reset
    config_valid = 1'b1;
    config_packet = pkt(3, 63, 0, 0);
    tick();
    config_valid = 1'b0;
    check("edge_noerr", config_error, 0);
    check("edge_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("edge_abort", busy, 0);
    check("edge_abort_rdy", write_weights_ready, 0);

    // mode 0, all lanes streaming
    start_job(0, 1'b0);
    run_read(1'b0, 1'b0);

    // mode 1 with a gapped fill
    start_job(1, 1'b1);
    run_read(1'b1, 1'b0);

    // mode 0, lane 2 every third cycle
    start_job(0, 1'b1);
    run_read(1'b0, 1'b1);

    // reset mid-read
    start_job(0, 1'b0);
    weight_request = '1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    weight_request = '0;
    check("mid_rst_valid", weight_valid, 0);
    check("mid_rst_last", weight_last, 0);
    check("mid_rst_out", weight_output, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", write_weights_ready, 0);
    check("mid_rst_done", done, 0);
    config_valid = 1'b1;
    config_packet = pkt(1, 2, 1, 0);
    tick();
    config_valid = 1'b0;
    check("post_rst_busy", busy, 1);
    check("post_rst_ready", write_weights_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
